// File: rtl/error_frame_scheduler_pkg.sv
// Shared types for the per-frame error scheduler: FSM states, colour channels
// and the mode encoding driven by the host.
package error_sched_pkg;

  typedef enum logic [1:0] {
    S_WAIT_SOP = 2'd0,
    S_MEASURE  = 2'd1,
    S_OFFER    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2
  } channel_t;

  localparam logic [1:0] MODE_RED   = 2'd0;
  localparam logic [1:0] MODE_GREEN = 2'd1;
  localparam logic [1:0] MODE_BLUE  = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'd3;

  // {blue, green, red}
  function automatic logic [2:0] ch_onehot(input channel_t ch);
    case (ch)
      CH_GREEN: ch_onehot = 3'b010;
      CH_BLUE:  ch_onehot = 3'b100;
      default:  ch_onehot = 3'b001;
    endcase
  endfunction

endpackage

// File: rtl/error_frame_scheduler_if.sv
// PID-side handshake: captured error offered with valid, consumed with ack.
interface error_frame_scheduler_if #(parameter int ERR_W = 32);
  logic signed [ERR_W-1:0] pid_error;
  logic                    pid_valid;
  logic                    pid_ack;

  modport master (output pid_error, output pid_valid, input pid_ack);
  modport slave  (input pid_error, input pid_valid, output pid_ack);
endinterface

// File: rtl/error_frame_scheduler_channel_rotator.sv
// Combinational channel helpers: next enabled channel in red->green->blue order
// and the lowest enabled channel of the mask.
module channel_rotator
  import error_sched_pkg::*;
#(
  parameter logic [2:0] COLOUR_MASK = 3'b111
) (
  input  channel_t cur_ch,
  output channel_t next_ch,
  output channel_t lowest_ch
);

  always_comb begin
    lowest_ch = CH_RED;
    if (!COLOUR_MASK[0]) lowest_ch = COLOUR_MASK[1] ? CH_GREEN : CH_BLUE;

    next_ch = cur_ch;
    case (cur_ch)
      CH_RED: begin
        if (COLOUR_MASK[1])      next_ch = CH_GREEN;
        else if (COLOUR_MASK[2]) next_ch = CH_BLUE;
      end
      CH_GREEN: begin
        if (COLOUR_MASK[2])      next_ch = CH_BLUE;
        else if (COLOUR_MASK[0]) next_ch = CH_RED;
      end
      CH_BLUE: begin
        if (COLOUR_MASK[0])      next_ch = CH_RED;
        else if (COLOUR_MASK[1]) next_ch = CH_GREEN;
      end
      default: next_ch = lowest_ch;
    endcase
  end

endmodule

// File: rtl/error_frame_scheduler.sv
// Per-frame scheduler: holds the measured colour channel for a frame, captures one
// error result per frame and offers it to the PID loop; tracks lost-line frames.
//   state      | meaning
//   S_WAIT_SOP | waiting for a frame start
//   S_MEASURE  | frame in progress, watching for a result edge
//   S_OFFER    | pid_valid high until acked
module error_frame_scheduler
  import error_sched_pkg::*;
#(
  parameter logic [2:0] COLOUR_MASK = 3'b111,
  parameter int         LOST_FRAMES = 4,
  parameter int         ERR_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startofpacket,
  input  logic [1:0]              mode,
  input  logic signed [ERR_W-1:0] err_in,
  input  logic                    err_ready_in,
  error_frame_scheduler_if.master pid_if,
  output logic                    red,
  output logic                    green,
  output logic                    blue,
  output logic                    line_lost,
  output logic                    overrun
);

  localparam logic [3:0] LOST_L = 4'(LOST_FRAMES);

  state_t                  state;
  channel_t                ch, next_ch, lowest_ch, fixed_ch;
  logic [3:0]              miss_cnt;
  logic                    ready_q;
  logic signed [ERR_W-1:0] err_q;
  logic                    valid_q;
  logic                    err_rise, miss;

  channel_rotator #(.COLOUR_MASK(COLOUR_MASK)) u_rot (
    .cur_ch   (ch),
    .next_ch  (next_ch),
    .lowest_ch(lowest_ch)
  );

  assign err_rise = err_ready_in & ~ready_q;
  assign miss     = (state == S_MEASURE) && startofpacket;

  always_comb begin
    fixed_ch = lowest_ch;
    case (mode)
      MODE_RED:   if (COLOUR_MASK[0]) fixed_ch = CH_RED;
      MODE_GREEN: if (COLOUR_MASK[1]) fixed_ch = CH_GREEN;
      MODE_BLUE:  if (COLOUR_MASK[2]) fixed_ch = CH_BLUE;
      default:    fixed_ch = lowest_ch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_WAIT_SOP;
      ch       <= lowest_ch;
      miss_cnt <= '0;
      ready_q  <= 1'b0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      ready_q <= err_ready_in;
      // Channel only moves on a frame boundary so a frame is measured on one colour.
      if (startofpacket) begin
        if (mode == MODE_AUTO) begin
          if (miss) ch <= next_ch;
        end else begin
          ch <= fixed_ch;
        end
      end
      case (state)
        S_WAIT_SOP: if (startofpacket) state <= S_MEASURE;
        S_MEASURE: begin
          if (startofpacket) begin
            if (miss_cnt != LOST_L) miss_cnt <= miss_cnt + 4'd1;
          end else if (err_rise) begin
            err_q    <= err_in;
            valid_q  <= 1'b1;
            miss_cnt <= '0;
            state    <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (pid_if.pid_ack) begin
            valid_q <= 1'b0;
            state   <= startofpacket ? S_MEASURE : S_WAIT_SOP;
          end else if (startofpacket) begin
            overrun <= 1'b1;
          end
        end
        default: state <= S_WAIT_SOP;
      endcase
    end
  end

  assign pid_if.pid_error = err_q;
  assign pid_if.pid_valid = valid_q;
  assign line_lost        = (miss_cnt == LOST_L);
  assign {blue, green, red} = ch_onehot(ch);

endmodule
